// File: rtl/bus_burst_memory_responder.sv
// bus_burst_memory_responder: single-port SRAM bus target serving burst reads and byte-enabled burst writes.
module bus_burst_memory_responder #(
  parameter logic [31:0] BASE_ADDRESS = 32'hF0000000,
  parameter int          SIZE_WORDS   = 1024,
  parameter string       INIT_FILE    = ""
) (
  input  logic        cpuClock,
  input  logic        cpuResetN,
  input  logic        beginTransactionIn,
  input  logic [31:0] addressDataIn,
  input  logic        readNotWriteIn,
  input  logic [3:0]  byteEnablesIn,
  input  logic [7:0]  burstSizeIn,
  input  logic        dataValidIn,
  input  logic        endTransactionIn,
  output logic [31:0] addressDataOut,
  output logic        dataValidOut,
  output logic        endTransactionOut,
  output logic        busErrorOut
);
  localparam int AW = $clog2(SIZE_WORDS);
`ifdef BUS_RESPONDER_WAIT_STATE_EN
  localparam bit WAIT_STATE = 1'b1;
`else
  localparam bit WAIT_STATE = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, READ_PREP, READ_BURST, READ_END, WRITE_BURST, ERROR, WAIT_END} state_t;
  state_t        r_state;
  logic [31:0]   r_mem [SIZE_WORDS];
  logic [AW-1:0] r_index;
  logic [7:0]    r_burst;
  logic [7:0]    r_cnt;
  logic [3:0]    r_be;
  logic          r_done;
  logic          r_gap;
  logic [31:0]   r_data;
  logic          r_valid;
  logic          r_end;
  logic          r_err;
  logic [AW-1:0] w_idx;
  logic [AW-1:0] w_addr;
  logic          w_sel;
  logic          w_over;
  logic          w_last;
  logic          w_we;

  assign w_idx  = addressDataIn[AW+1:2];
  assign w_sel  = beginTransactionIn && (addressDataIn[31:AW+2] == BASE_ADDRESS[31:AW+2]);
  assign w_over = (32'(w_idx) + 32'(burstSizeIn)) > 32'(SIZE_WORDS - 1);
  assign w_addr = r_index + AW'(r_cnt);
  assign w_last = r_cnt == r_burst;
  assign w_we   = cpuResetN && r_state == WRITE_BURST && dataValidIn && !r_done;

  assign addressDataOut    = r_data;
  assign dataValidOut      = r_valid;
  assign endTransactionOut = r_end;
  assign busErrorOut       = r_err;

  always_ff @(posedge cpuClock) begin
    if (!cpuResetN) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_gap   <= 1'b0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_end   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_end   <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        IDLE: if (w_sel) begin
          r_index <= w_idx;
          r_burst <= burstSizeIn;
          r_be    <= byteEnablesIn;
          r_cnt   <= '0;
          r_done  <= 1'b0;
          r_gap   <= 1'b0;
          if (w_over) begin
            r_err   <= 1'b1;
            r_state <= ERROR;
          end else
            r_state <= readNotWriteIn ? READ_PREP : WRITE_BURST;
        end
        READ_PREP, READ_BURST:
          if (endTransactionIn)
            r_state <= IDLE;
          else if (r_gap)
            r_gap <= 1'b0;
          else begin
            r_data  <= r_mem[w_addr];
            r_valid <= 1'b1;
            if (w_last)
              r_state <= READ_END;
            else begin
              r_cnt   <= r_cnt + 8'd1;
              r_gap   <= WAIT_STATE;
              r_state <= READ_BURST;
            end
          end
        READ_END: begin
          r_end   <= 1'b1;
          r_state <= IDLE;
        end
        WRITE_BURST: begin
          if (w_we) begin
            if (w_last)
              r_done <= 1'b1;
            else
              r_cnt <= r_cnt + 8'd1;
          end
          if (endTransactionIn)
            r_state <= IDLE;
        end
        ERROR:    r_state <= endTransactionIn ? IDLE : WAIT_END;
        WAIT_END: if (endTransactionIn) r_state <= IDLE;
        default:  r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge cpuClock) begin
    if (w_we)
      for (int b = 0; b < 4; b++)
        if (r_be[b]) r_mem[w_addr][8*b +: 8] <= addressDataIn[8*b +: 8];
  end
endmodule
